fifo_pattern_gen: RTL and testbench



---
 rtl/fifo_pattern_gen.sv | 133 +++++++++++++
 tb/tb_fifo_pattern_gen.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/fifo_pattern_gen.sv
// fifo_pattern_gen: writes fixed-length bursts of pattern words into the FIFO
// that feeds the Xillybus read pipe. Bursts start only when en is high and
// prog_full is low. Once started, a burst always completes, and fifo_full
// stalls it without losing words.
// Build option: define PATTERN_LFSR_EN to replace the incrementing counter
// with a 32-bit Galois LFSR (x^32+x^22+x^2+x+1, seed 0xFFFFFFFF, DATA_W=32).
module fifo_pattern_gen #(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned BURST_LEN  = 256,
  parameter int unsigned GAP_CYCLES = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              prog_full,
  input  logic              fifo_full,
  output logic              wr_en,
  output logic [DATA_W-1:0] din,
  output logic              burst_done,
  output logic [31:0]       word_count
);

  localparam int unsigned BEAT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam int unsigned GAP_W  = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(BURST_LEN - 1);
  localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

`ifdef PATTERN_LFSR_EN
  localparam logic [DATA_W-1:0] SEED = '1;
  localparam logic [31:0]       TAPS = 32'h8020_0003;

  // The LFSR is defined for 32-bit words only.
  if (DATA_W != 32) begin : g_bad_width
    $error("fifo_pattern_gen: PATTERN_LFSR_EN requires DATA_W == 32");
  end

  // One Galois step, shifting right and folding the taps in when bit 0 is set.
  function automatic logic [DATA_W-1:0] next_pattern(input logic [DATA_W-1:0] cur);
    logic [DATA_W-1:0] shifted;
    shifted = cur >> 1;
    return cur[0] ? (shifted ^ DATA_W'(TAPS)) : shifted;
  endfunction
`else
  localparam logic [DATA_W-1:0] SEED = '0;

  // Incrementing counter that wraps at 2^DATA_W.
  function automatic logic [DATA_W-1:0] next_pattern(input logic [DATA_W-1:0] cur);
    return cur + DATA_W'(1);
  endfunction
`endif

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_BURST = 2'd1,
    S_GAP   = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [DATA_W-1:0]   din_q, din_d;
  logic [BEAT_W-1:0]   beat_q, beat_d;
  logic [GAP_W-1:0]    gap_q, gap_d;
  logic                done_q, done_d;
  logic [31:0]         wc_q, wc_d;

  // Next-state and datapath. wr_en is the one combinational output and
  // follows fifo_full in the same cycle, so a stall costs exactly one beat.
  always_comb begin
    state_d = state_q;
    din_d   = din_q;
    beat_d  = beat_q;
    gap_d   = gap_q;
    done_d  = 1'b0;
    wc_d    = wc_q;
    wr_en   = (state_q == S_BURST) && !fifo_full;

    case (state_q)
      S_IDLE: begin
        if (en && !prog_full) begin
          state_d = S_BURST;
        end
      end
      S_BURST: begin
        if (wr_en) begin
          din_d = next_pattern(din_q);
          wc_d  = wc_q + 32'd1;
          if (beat_q == BEAT_LAST) begin
            beat_d  = '0;
            done_d  = 1'b1;
            gap_d   = '0;
            state_d = (GAP_CYCLES > 0) ? S_GAP : S_IDLE;
          end else begin
            beat_d = beat_q + BEAT_W'(1);
          end
        end
      end
      S_GAP: begin
        if (gap_q == GAP_LAST) begin
          gap_d   = '0;
          state_d = S_IDLE;
        end else begin
          gap_d = gap_q + GAP_W'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers. Reset restarts the pattern from the seed.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      din_q   <= SEED;
      beat_q  <= '0;
      gap_q   <= '0;
      done_q  <= 1'b0;
      wc_q    <= '0;
    end else begin
      state_q <= state_d;
      din_q   <= din_d;
      beat_q  <= beat_d;
      gap_q   <= gap_d;
      done_q  <= done_d;
      wc_q    <= wc_d;
    end
  end

  assign din        = din_q;
  assign burst_done = done_q;
  assign word_count = wc_q;

endmodule

// File: tb/tb_fifo_pattern_gen.sv
// tb_fifo_pattern_gen: directed bench for fifo_pattern_gen (BURST_LEN=8,
// GAP_CYCLES=4). Expected words are queued when a burst is enabled and are
// popped as the DUT writes them.
module tb_fifo_pattern_gen;

  localparam int unsigned DATA_W     = 32;
  localparam int unsigned BURST_LEN  = 8;
  localparam int unsigned GAP_CYCLES = 4;

`ifdef PATTERN_LFSR_EN
  localparam logic [31:0] SEED = 32'hFFFF_FFFF;
`else
  localparam logic [31:0] SEED = 32'h0000_0000;
`endif

  logic              clk;
  logic              rst_n;
  logic              en;
  logic              prog_full;
  logic              fifo_full;
  logic              wr_en;
  logic [DATA_W-1:0] din;
  logic              burst_done;
  logic [31:0]       word_count;

  fifo_pattern_gen #(
    .DATA_W    (DATA_W),
    .BURST_LEN (BURST_LEN),
    .GAP_CYCLES(GAP_CYCLES)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .prog_full (prog_full),
    .fifo_full (fifo_full),
    .wr_en     (wr_en),
    .din       (din),
    .burst_done(burst_done),
    .word_count(word_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          errors = 0;
  int          checks = 0;
  logic [31:0] sb[$];
  logic [31:0] mdl_pat;
  logic [31:0] mdl_wc;
  int          mdl_beat;
  logic        exp_done;

  // Reference pattern step.
  function automatic logic [31:0] ref_next(input logic [31:0] cur);
`ifdef PATTERN_LFSR_EN
    logic [31:0] s;
    s = cur >> 1;
    if (cur[0]) s = s ^ 32'h8020_0003;
    return s;
`else
    return cur + 32'd1;
`endif
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Queue the words of one burst.
  task automatic push_burst();
    for (int i = 0; i < int'(BURST_LEN); i++) begin
      sb.push_back(mdl_pat);
      mdl_pat = ref_next(mdl_pat);
    end
  endtask

  // Check one cycle mid-cycle, update the model, then move past the next edge.
  task automatic cyc(input logic exp_wr);
    logic        nx_done;
    logic [31:0] exp_din;
    @(negedge clk);
    chk("wr_en", {31'd0, wr_en}, {31'd0, exp_wr});
    chk("burst_done", {31'd0, burst_done}, {31'd0, exp_done});
    chk("word_count", word_count, mdl_wc);
    nx_done = 1'b0;
    if (wr_en === 1'b1 && rst_n === 1'b1) begin
      if (sb.size() == 0) begin
        chk("unexpected_write", din, 32'hDEAD_BEEF);
      end else begin
        exp_din = sb.pop_front();
        chk("din", din, exp_din);
      end
      mdl_wc = mdl_wc + 32'd1;
      mdl_beat++;
      if (mdl_beat == int'(BURST_LEN)) begin
        mdl_beat = 0;
        nx_done  = 1'b1;
      end
    end
    exp_done = nx_done;
    @(posedge clk);
    #1;
  endtask

  // One reset edge, then release; the model restarts with the DUT.
  task automatic do_reset();
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    sb.delete();
    mdl_pat  = SEED;
    mdl_wc   = 32'd0;
    mdl_beat = 0;
    exp_done = 1'b0;
    rst_n    = 1'b1;
    chk("rst_din", din, SEED);
    chk("rst_wc", word_count, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n     = 1'b0;
    en        = 1'b1;
    prog_full = 1'b0;
    fifo_full = 1'b0;
    mdl_pat   = SEED;
    mdl_wc    = 32'd0;
    mdl_beat  = 0;
    exp_done  = 1'b0;
    @(posedge clk);
    #1;

    // Reset held with en high: nothing moves.
    repeat (3) begin
      chk("rst_hold_din", din, SEED);
      cyc(1'b0);
    end
    rst_n = 1'b1;

    // Single burst, gap, idle, then a second burst continuing the pattern.
    push_burst();
    cyc(1'b0);
    repeat (BURST_LEN) cyc(1'b1);
    repeat (GAP_CYCLES + 1) cyc(1'b0);
    push_burst();
    repeat (BURST_LEN) cyc(1'b1);
    en = 1'b0;
    repeat (GAP_CYCLES + 4) cyc(1'b0);
    chk("two_burst_wc", word_count, 32'd16);

    // Stall for 5 cycles after the third write.
    do_reset();
    en = 1'b1;
    push_burst();
    cyc(1'b0);
    repeat (3) cyc(1'b1);
    fifo_full = 1'b1;
    repeat (5) begin
      chk("stall_din", din, sb[0]);
      cyc(1'b0);
    end
    fifo_full = 1'b0;
    repeat (BURST_LEN - 3) cyc(1'b1);
    en = 1'b0;
    repeat (GAP_CYCLES + 1) cyc(1'b0);
    chk("stall_wc", word_count, 32'd8);

    // prog_full blocks start; prog_full and en dropping mid-burst do not stop it.
    do_reset();
    prog_full = 1'b1;
    en        = 1'b1;
    repeat (4) cyc(1'b0);
    prog_full = 1'b0;
    push_burst();
    cyc(1'b0);
    repeat (2) cyc(1'b1);
    prog_full = 1'b1;
    en        = 1'b0;
    repeat (BURST_LEN - 2) cyc(1'b1);
    prog_full = 1'b0;
    repeat (GAP_CYCLES + 4) cyc(1'b0);
    chk("gate_wc", word_count, 32'd8);

    // Reset after 5 writes of a burst, then a fresh burst from the seed.
    do_reset();
    en = 1'b1;
    push_burst();
    cyc(1'b0);
    repeat (5) cyc(1'b1);
    do_reset();
    push_burst();
    cyc(1'b0);
    repeat (BURST_LEN) cyc(1'b1);
    en = 1'b0;
    repeat (GAP_CYCLES + 2) cyc(1'b0);
    chk("mid_rst_wc", word_count, 32'd8);

    chk("sb_empty", 32'(sb.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
